// File: rtl/xbar_slot_scheduler.sv
`default_nettype none
// ============================================================================
// xbar_slot_scheduler: 4x4 crossbar slot sequencer and per-output arbiter.
// Define XBAR_SCHED_RR_EN for round-robin; otherwise fixed lowest-index priority.
// Rev 1.0
// ============================================================================
module xbar_slot_scheduler #(
  parameter int CLR_LEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  req_v,
  output logic [3:0]  req_ready,
  input  logic [31:0] req_pld,
  input  logic [7:0]  req_d,
  input  logic [7:0]  req_s,
  output logic [3:0]  fab_v,
  output logic [31:0] fab_pld,
  output logic [7:0]  fab_d,
  output logic [7:0]  fab_s,
  output logic [1:0]  fab_slot,
  output logic        fab_clr,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [3:0] c_clr_init = 4'(CLR_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SLOT  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_clr_cnt;
  logic [1:0] r_slot;
  logic [3:0] w_grant;

`ifdef XBAR_SCHED_RR_EN
  logic [3:0][1:0] r_ptr;
  logic [3:0]      w_hit;
  logic [3:0][1:0] w_win;

  // Search each output's candidates starting at its pointer, wrapping mod 4.
  always_comb begin
    logic [1:0] w_idx;
    w_idx   = '0;
    w_grant = '0;
    w_hit   = '0;
    w_win   = '0;
    if (r_state == ST_SLOT) begin
      for (int o = 0; o < 4; o++) begin
        for (int k = 0; k < 4; k++) begin
          w_idx = r_ptr[o] + 2'(k);
          if (!w_hit[o] && req_v[w_idx] && (req_d[{w_idx, 1'b0} +: 2] == 2'(o))) begin
            w_grant[w_idx] = 1'b1;
            w_hit[o]       = 1'b1;
            w_win[o]       = w_idx;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        if (w_hit[o]) begin
          r_ptr[o] <= w_win[o] + 2'd1;
        end
      end
    end
  end
`else
  always_comb begin
    logic [3:0] w_taken;
    w_grant = '0;
    w_taken = '0;
    if (r_state == ST_SLOT) begin
      for (int i = 0; i < 4; i++) begin
        if (req_v[i] && !w_taken[req_d[2*i +: 2]]) begin
          w_grant[i]                = 1'b1;
          w_taken[req_d[2*i +: 2]]  = 1'b1;
        end
      end
    end
  end
`endif

  assign req_ready = w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_slot     <= '0;
      fab_v      <= '0;
      fab_pld    <= '0;
      fab_d      <= '0;
      fab_s      <= '0;
      fab_slot   <= '0;
      fab_clr    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fab_v      <= w_grant;
      fab_slot   <= (r_state == ST_SLOT) ? r_slot : 2'd0;
      fab_clr    <= (r_state == ST_CLEAR);
      frame_done <= 1'b0;
      // Non-granted lanes keep their last payload.
      for (int i = 0; i < 4; i++) begin
        if (w_grant[i]) begin
          fab_pld[8*i +: 8] <= req_pld[8*i +: 8];
          fab_d[2*i +: 2]   <= req_d[2*i +: 2];
          fab_s[2*i +: 2]   <= req_s[2*i +: 2];
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= c_clr_init;
            busy      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == '0) begin
            r_state <= ST_SLOT;
            r_slot  <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt - 4'd1;
          end
        end
        ST_SLOT: begin
          if (r_slot == 2'd3) begin
            frame_done <= 1'b1;
            r_slot     <= '0;
            if (en) begin
              r_state   <= ST_CLEAR;
              r_clr_cnt <= c_clr_init;
            end else begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_slot <= r_slot + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_slot_scheduler.sv
`default_nettype none
// ============================================================================
// tb_xbar_slot_scheduler: scoreboard bench for xbar_slot_scheduler (CLR_LEN=2).
// Rev 1.0
// ============================================================================
module tb_xbar_slot_scheduler;

  localparam int CLR_LEN = 2;
`ifdef XBAR_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_v;
  logic [3:0]  req_ready;
  logic [31:0] req_pld;
  logic [7:0]  req_d;
  logic [7:0]  req_s;
  logic [3:0]  fab_v;
  logic [31:0] fab_pld;
  logic [7:0]  fab_d;
  logic [7:0]  fab_s;
  logic [1:0]  fab_slot;
  logic        fab_clr;
  logic        busy;
  logic        frame_done;

  xbar_slot_scheduler #(.CLR_LEN(CLR_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_v      (req_v),
    .req_ready  (req_ready),
    .req_pld    (req_pld),
    .req_d      (req_d),
    .req_s      (req_s),
    .fab_v      (fab_v),
    .fab_pld    (fab_pld),
    .fab_d      (fab_d),
    .fab_s      (fab_s),
    .fab_slot   (fab_slot),
    .fab_clr    (fab_clr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] pld;
    logic [7:0]  d;
    logic [7:0]  s;
    logic [1:0]  slot;
    logic        clr;
    logic        fd;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          k;
  int          start_k;
  int          stop_k;
  logic [31:0] sh_pld = '0;
  logic [7:0]  sh_d   = '0;
  logic [7:0]  sh_s   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, k, got, exp);
    end
  endtask

  // Frame position from the documented timing: idle=5, clear=4, slot n=n.
  function automatic int phase(input int kk);
    int r;
    if (kk <= start_k || kk > stop_k) return 5;
    r = (kk - start_k - 1) % (CLR_LEN + 4);
    return (r < CLR_LEN) ? 4 : r - CLR_LEN;
  endfunction

  task automatic cyc(input logic [3:0] exp_rdy);
    int   p;
    exp_t e;
    #1;
    p = phase(k);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(p != 5));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        sh_pld[8*i +: 8] = req_pld[8*i +: 8];
        sh_d[2*i +: 2]   = req_d[2*i +: 2];
        sh_s[2*i +: 2]   = req_s[2*i +: 2];
      end
    end
    e.v    = exp_rdy;
    e.pld  = sh_pld;
    e.d    = sh_d;
    e.s    = sh_s;
    e.slot = (p < 4) ? 2'(p) : 2'd0;
    e.clr  = (p == 4);
    e.fd   = (p == 3);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    k++;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("fab_v",      32'(fab_v),      32'(e.v));
      chk("fab_pld",    fab_pld,         e.pld);
      chk("fab_d",      32'(fab_d),      32'(e.d));
      chk("fab_s",      32'(fab_s),      32'(e.s));
      chk("fab_slot",   32'(fab_slot),   32'(e.slot));
      chk("fab_clr",    32'(fab_clr),    32'(e.clr));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; req_v = '0; req_pld = '0; req_d = '0; req_s = '0;
    k = 0; start_k = 0; stop_k = 1 << 30;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'h0);
    chk("rst_fab_v",      32'(fab_v),      32'h0);
    chk("rst_fab_pld",    fab_pld,         32'h0);
    chk("rst_fab_slot",   32'(fab_slot),   32'h0);
    chk("rst_fab_clr",    32'(fab_clr),    32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    // Empty frames: clear gap, slots 0..3, frame_done, period CLR_LEN+4.
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 15; i++) cyc(4'h0);

    // All inputs contend for output 2 in slots 0..3 (k=15..18).
    req_v = 4'hF; req_d = 8'hAA; req_pld = 32'hC3C2C1C0; req_s = 8'hE4;
    for (int i = 0; i < 4; i++) cyc(RR ? 4'(1 << i) : 4'h1);
    // Held through the clear gap, then pointer wrapped back to input 0.
    cyc(4'h0);
    cyc(4'h0);
    cyc(4'h1);
    req_v = 4'h0;
    for (int i = 0; i < 3; i++) cyc(4'h0);

    // Distinct destinations requested during clear; all granted in slot 0.
    req_v = 4'hF; req_d = 8'hE4; req_pld = 32'hA3A2A1A0; req_s = 8'h1B;
    cyc(4'h0);
    cyc(4'h0);
    cyc(4'hF);

    // Drop en in slot 1: frame completes, then idle with no more clears.
    req_v = 4'h0;
    en = 1'b0;
    stop_k = 30;
    for (int i = 0; i < 8; i++) cyc(4'h0);

    // Restart, then reset during slot 2 with grants pending.
    en = 1'b1;
    start_k = 36;
    stop_k = 1 << 30;
    for (int i = 0; i < 5; i++) cyc(4'h0);
    req_v = 4'hF;
    #1;
    chk("pre_rst_req_ready", 32'(req_ready), 32'hF);
    rst = 1'b1;
    #1;
    chk("async_rst_req_ready", 32'(req_ready), 32'h0);
    chk("async_rst_fab_v",     32'(fab_v),     32'h0);
    chk("async_rst_fab_pld",   fab_pld,        32'h0);
    chk("async_rst_fab_d",     32'(fab_d),     32'h0);
    chk("async_rst_fab_slot",  32'(fab_slot),  32'h0);
    chk("async_rst_busy",      32'(busy),      32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_fab_v",   32'(fab_v),   32'h0);
    chk("post_rst_fab_clr", 32'(fab_clr), 32'h0);
    chk("post_rst_busy",    32'(busy),    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xbar_slot_scheduler.md
# xbar_slot_scheduler

Slot sequencer and output-port arbiter for the 4x4 crossbar mux fabric. Accepts one packet request per input port through a valid/ready handshake. Resolves output-port contention with a per-output round-robin arbiter. Drives the fabric's per-input payload/dest/source/valid buses plus the shared `slot` and `clr` controls, framing traffic into 4-slot frames separated by a programmable clear gap.

## Interface
- `CLR_LEN`, default 1: fabric clear cycles before each frame; legal range 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scheduler enable; sampled in IDLE and at end of slot 3.
- `req_v` in 4: per-input request valid, bit i = input i.
- `req_ready` out 4: per-input grant; combinational from `req_v`, `req_d`, state and pointers.
- `req_pld` in 32: payloads, [8i+7:8i] = input i.
- `req_d` in 8: destination output ports, [2i+1:2i] = input i.
- `req_s` in 8: source tags, [2i+1:2i] = input i.
- `fab_v` out 4: registered valid to fabric (ipNv).
- `fab_pld` out 32: registered payload to fabric (ipNpld).
- `fab_d` out 8: registered destination to fabric (ipNd).
- `fab_s` out 8: registered source tag to fabric (ipNs).
- `fab_slot` out 2: registered slot number to fabric.
- `fab_clr` out 1: registered fabric clear.
- `busy` out 1: high in CLEAR and SLOT states.
- `frame_done` out 1: one-cycle pulse, registered, after slot 3 completes.

## Operation
- States: IDLE, CLEAR, SLOT. Reset enters IDLE.
- IDLE:
  - `req_ready`=0.
  - `en`=1 → CLEAR with clear counter loaded to CLR_LEN-1.
- CLEAR:
  - `fab_clr`=1, `fab_v`=0, `fab_slot`=0, `req_ready`=0.
  - Counter decrements each cycle; at 0 → SLOT with slot counter 0.
- SLOT: slot counter runs 0,1,2,3, one cycle each. At slot 3:
  - `en`=1 → CLEAR.
  - `en`=0 → IDLE.
  - Either way, `frame_done` pulses the next cycle.
- Arbitration in SLOT, per output o:
  - Candidates are inputs i with `req_v[i]` and `req_d[i]`==o.
  - Winner is the first candidate at or after `ptr[o]`, modulo 4.
  - `req_ready[i]`=1 only for winners. At most one grant per output; at most 4 grants per cycle.
  - A transfer occurs when `req_v[i]` and `req_ready[i]` are both high.
- Pointer update: on a grant to input w at output o, `ptr[o]` <= w+1, mod 4 wrap (3 → 0). Pointers with no grant hold.
- Fabric drive, registered:
  - For a granted input i: `fab_v[i]`=1; `fab_pld`, `fab_d`, `fab_s` lanes i = request fields.
  - For a non-granted input: `fab_v[i]`=0; data lanes hold their previous value.
  - `fab_slot` = slot counter of the grant cycle.
- Requester rule: once `req_v[i]` is high, it and its data stay stable until granted. The block does not check this.
- `en` deasserted mid-frame: the current frame finishes through slot 3, then → IDLE.
- `rst` mid-frame: all state clears immediately. Any grant in that cycle is lost.

## Timing
- Reset values: `req_ready`=0, all `fab_*`=0, `busy`=0, `frame_done`=0, all `ptr`=0, slot and clear counters 0.
- Grant to fabric latency: 1 cycle. The grant in cycle n appears on `fab_v`/data/`fab_slot` in cycle n+1.
- `fab_clr`:
  - Asserted the cycle after entering CLEAR, for exactly CLR_LEN cycles.
  - Never overlaps `fab_v`≠0.
- Frame period: CLR_LEN+4 cycles while `en`=1 continuously.
- IDLE→first grant: CLR_LEN+1 cycles after `en` is sampled high.
- `busy` is registered and asserted the cycle after leaving IDLE.

## Configuration
- `XBAR_SCHED_RR_EN`:
  - Defined: round-robin arbitration with the per-output pointers, as above.
  - Undefined: fixed priority, lowest input index wins; pointers are removed and grants are a pure function of `req_v`/`req_d`.

## Test plan
- Reset then `en`=1, CLR_LEN=2, no requests → `fab_clr` high 2 cycles, `fab_slot` 0,1,2,3, `frame_done` one pulse, repeating every 6 cycles.
- All four inputs request distinct outputs (d=0,1,2,3), pld=8'hA0..A3 → `req_ready`=4'hF in slot 0; next cycle `fab_v`=4'hF, `fab_pld`=32'hA3A2A1A0.
- All four inputs request output 2, held across slots → grants in order input 0,1,2,3, one per slot, `ptr[2]` wraps to 0. Without the macro, input 0 wins every slot.
- Request during CLEAR → `req_ready`=0 until slot 0, then granted with `fab_slot`=0.
- Drop `en` during slot 1 → slots 2,3 complete, `frame_done` pulses, state → IDLE, `busy`=0, no further `fab_clr`.
- Assert `rst` during slot 2 with a grant pending → all outputs 0 the same cycle; after release, IDLE with `req_ready`=0.
